// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage issue interlock: GPR address width,
// scoreboard counter sizing and the per-stage result broadcast bundle.
// Pure definitions; no latency or backpressure of its own.
package hazard_ctrl_pkg;

    localparam int GPR_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int SB_CNT_W   = 2;
    localparam int SB_CNT_MAX = (1 << SB_CNT_W) - 1;

    // Result broadcast from one downstream stage (EX, MEM or WB).
    typedef struct packed {
        logic                  vld;
        logic                  we;
        logic [GPR_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  data_ok;
    } stage_bc_t;

    // True when the stage holds a live writer of register a.
    function automatic logic stage_hit(input stage_bc_t s, input logic [GPR_ADDR_W-1:0] a);
        return s.vld & s.we & (s.waddr == a);
    endfunction

endpackage

// File: rtl/hazard_port_sel.sv
// Bypass selection for one decode read port: youngest-writer match over EX/MEM/WB.
// Latency: purely combinational, 0 cycles.
// Backpressure: raises stall when the youngest writer's result is not final yet.
//
// Ports: id_valid/raddr  - decode read request
//        ex_bc/mem_bc/wb_bc - stage broadcasts (wb_bc.data_ok tied high by the parent)
//        cnt_busy       - scoreboard says a writer of raddr is in flight
//        occur/forward  - bypass hit and its data; stall - port must wait
module hazard_port_sel
    import hazard_ctrl_pkg::*;
(
    input  logic                  id_valid,
    input  logic [GPR_ADDR_W-1:0] raddr,
    input  stage_bc_t             ex_bc,
    input  stage_bc_t             mem_bc,
    input  stage_bc_t             wb_bc,
    input  logic                  cnt_busy,
    output logic                  occur,
    output logic [DATA_W-1:0]     forward,
    output logic                  stall
);

    always_comb begin
        occur   = 1'b0;
        forward = '0;
        stall   = 1'b0;
        if (id_valid && (raddr != '0)) begin
            // Only the youngest matching stage decides; an unready EX result
            // must not fall through to an older, stale MEM/WB value.
            if (stage_hit(ex_bc, raddr)) begin
                if (ex_bc.data_ok) begin
                    occur   = 1'b1;
                    forward = ex_bc.wdata;
                end else begin
                    stall = 1'b1;
                end
            end else if (stage_hit(mem_bc, raddr)) begin
                if (mem_bc.data_ok) begin
                    occur   = 1'b1;
                    forward = mem_bc.wdata;
                end else begin
                    stall = 1'b1;
                end
            end else if (stage_hit(wb_bc, raddr)) begin
                if (wb_bc.data_ok) begin
                    occur   = 1'b1;
                    forward = wb_bc.wdata;
                end else begin
                    stall = 1'b1;
                end
            end else begin
                // Writer exists but sits in a stage whose valid is masked.
                stall = cnt_busy;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue interlock: per-GPR in-flight writer scoreboard plus bypass select.
// Latency: 0 cycles broadcast-to-forward; scoreboard updates on the next clk edge.
// Backpressure: pause stalls ID while a needed operand is not yet available.
//
// Ports: clk/reset (sync, active high); id_* issue handshake and read addresses;
//        ex_/mem_/wb_* stage broadcasts; wb_retire; flush;
//        pause, addrN_occur/addrN_forward outputs; sb_err sticky counter fault.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_fire,
    input  logic                  id_rf_we,
    input  logic [GPR_ADDR_W-1:0] id_waddr,
    input  logic [GPR_ADDR_W-1:0] id_raddr1,
    input  logic [GPR_ADDR_W-1:0] id_raddr2,
    input  logic                  ex_valid,
    input  logic                  mem_valid,
    input  logic                  wb_valid,
    input  logic                  ex_we,
    input  logic                  mem_we,
    input  logic                  wb_we,
    input  logic [GPR_ADDR_W-1:0] ex_waddr,
    input  logic [GPR_ADDR_W-1:0] mem_waddr,
    input  logic [GPR_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     wb_wdata,
    input  logic                  ex_data_ok,
    input  logic                  mem_data_ok,
    input  logic                  wb_retire,
    input  logic                  flush,
    output logic                  pause,
    output logic                  addr1_occur,
    output logic                  addr2_occur,
    output logic [DATA_W-1:0]     addr1_forward,
    output logic [DATA_W-1:0]     addr2_forward,
    output logic                  sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // r0 has no counter; it is never a hazard.
    logic [CNT_W-1:0] cnt     [1:NREG-1];
    logic [CNT_W-1:0] cnt_nxt [1:NREG-1];
    logic             cnt_err;
    logic             issue_we;
    logic             retire_we;
    logic             busy1;
    logic             busy2;
    logic             stall1;
    logic             stall2;

    stage_bc_t ex_bc;
    stage_bc_t mem_bc;
    stage_bc_t wb_bc;

    assign ex_bc  = '{vld: ex_valid,  we: ex_we,  waddr: ex_waddr,  wdata: ex_wdata,  data_ok: ex_data_ok};
    assign mem_bc = '{vld: mem_valid, we: mem_we, waddr: mem_waddr, wdata: mem_wdata, data_ok: mem_data_ok};
    // WB results are always final; the RF write lands at the same edge.
    assign wb_bc  = '{vld: wb_valid,  we: wb_we,  waddr: wb_waddr,  wdata: wb_wdata,  data_ok: 1'b1};

    // Issue during a flush belongs to a killed instruction.
    assign issue_we  = id_fire & id_rf_we & ~flush;
    assign retire_we = wb_retire & wb_valid & wb_we;

    always_comb begin
        cnt_err = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            cnt_nxt[i] = cnt[i];
            if (issue_we && (id_waddr == GPR_ADDR_W'(i)) &&
                !(retire_we && (wb_waddr == GPR_ADDR_W'(i)))) begin
                if (cnt[i] == CNT_MAX) cnt_err = 1'b1;
                else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end else if (retire_we && (wb_waddr == GPR_ADDR_W'(i)) &&
                         !(issue_we && (id_waddr == GPR_ADDR_W'(i)))) begin
                if (cnt[i] == '0) cnt_err = 1'b1;
                else              cnt_nxt[i] = cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) cnt[i] <= '0;
            sb_err <= 1'b0;
        end else if (flush) begin
            // Everything younger than WB dies; WB retires by this edge, so
            // clearing every counter also covers a same-cycle retire.
            for (int i = 1; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) cnt[i] <= cnt_nxt[i];
            sb_err <= sb_err | cnt_err;
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if ((id_raddr1 == GPR_ADDR_W'(i)) && (cnt[i] != '0)) busy1 = 1'b1;
            if ((id_raddr2 == GPR_ADDR_W'(i)) && (cnt[i] != '0)) busy2 = 1'b1;
        end
    end

    hazard_port_sel u_port1 (
        .id_valid (id_valid),
        .raddr    (id_raddr1),
        .ex_bc    (ex_bc),
        .mem_bc   (mem_bc),
        .wb_bc    (wb_bc),
        .cnt_busy (busy1),
        .occur    (addr1_occur),
        .forward  (addr1_forward),
        .stall    (stall1)
    );

    hazard_port_sel u_port2 (
        .id_valid (id_valid),
        .raddr    (id_raddr2),
        .ex_bc    (ex_bc),
        .mem_bc   (mem_bc),
        .wb_bc    (wb_bc),
        .cnt_busy (busy2),
        .occur    (addr2_occur),
        .forward  (addr2_forward),
        .stall    (stall2)
    );

    assign pause = id_valid & (stall1 | stall2) & ~flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
// Inputs change 1 time unit after posedge; outputs are sampled mid-cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_fire, id_rf_we;
    logic [4:0]  id_waddr, id_raddr1, id_raddr2;
    logic        ex_valid, mem_valid, wb_valid;
    logic        ex_we, mem_we, wb_we;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    logic        ex_data_ok, mem_data_ok, wb_retire, flush;
    logic        pause, addr1_occur, addr2_occur, sb_err;
    logic [31:0] addr1_forward, addr2_forward;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_fire(id_fire), .id_rf_we(id_rf_we),
        .id_waddr(id_waddr), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
        .ex_wdata(ex_wdata), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
        .ex_data_ok(ex_data_ok), .mem_data_ok(mem_data_ok),
        .wb_retire(wb_retire), .flush(flush),
        .pause(pause), .addr1_occur(addr1_occur), .addr2_occur(addr2_occur),
        .addr1_forward(addr1_forward), .addr2_forward(addr2_forward),
        .sb_err(sb_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int LIMIT = 3;
    int   m_cnt [32];
    logic m_err = 1'b0;
    logic m_inc, m_dec;
    logic chk_en = 1'b0;

    initial foreach (m_cnt[i]) m_cnt[i] = 0;

    always @(posedge clk) begin
        m_inc = id_fire && id_rf_we && (id_waddr != 0);
        m_dec = wb_retire && wb_valid && wb_we && (wb_waddr != 0);
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err = 1'b0;
        end else if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (!(m_inc && m_dec && id_waddr == wb_waddr)) begin
            if (m_inc) begin
                if (m_cnt[id_waddr] == LIMIT) m_err = 1'b1;
                else m_cnt[id_waddr] = m_cnt[id_waddr] + 1;
            end
            if (m_dec) begin
                if (m_cnt[wb_waddr] == 0) m_err = 1'b1;
                else m_cnt[wb_waddr] = m_cnt[wb_waddr] - 1;
            end
        end
    end

    // Scan stages youngest first; the first writer found decides.
    function automatic void model_port(input logic [4:0] a, output logic st,
                                       output logic oc, output logic [31:0] fw);
        logic        v  [3];
        logic        ok [3];
        logic [4:0]  wa [3];
        logic [31:0] d  [3];
        v[0] = ex_valid && ex_we;   ok[0] = ex_data_ok;  wa[0] = ex_waddr;  d[0] = ex_wdata;
        v[1] = mem_valid && mem_we; ok[1] = mem_data_ok; wa[1] = mem_waddr; d[1] = mem_wdata;
        v[2] = wb_valid && wb_we;   ok[2] = 1'b1;        wa[2] = wb_waddr;  d[2] = wb_wdata;
        st = 1'b0; oc = 1'b0; fw = '0;
        if (!id_valid || a == 0) return;
        for (int k = 0; k < 3; k++) begin
            if (v[k] && wa[k] == a) begin
                if (ok[k]) begin oc = 1'b1; fw = d[k]; end
                else st = 1'b1;
                return;
            end
        end
        st = (m_cnt[a] != 0);
    endfunction

    logic        s1, o1, s2, o2;
    logic [31:0] f1, f2;

    always @(negedge clk) begin
        if (chk_en) begin
            model_port(id_raddr1, s1, o1, f1);
            model_port(id_raddr2, s2, o2, f2);
            check("m_pause", pause, id_valid && (s1 || s2) && !flush);
            check("m_occur1", addr1_occur, o1);
            check("m_occur2", addr2_occur, o2);
            if (o1) check("m_fwd1", addr1_forward, f1);
            if (o2) check("m_fwd2", addr2_forward, f2);
            check("m_sb_err", sb_err, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        id_valid = 0; id_fire = 0; id_rf_we = 0; id_waddr = 0; id_raddr1 = 0; id_raddr2 = 0;
        ex_valid = 0; mem_valid = 0; wb_valid = 0; ex_we = 0; mem_we = 0; wb_we = 0;
        ex_waddr = 0; mem_waddr = 0; wb_waddr = 0; ex_wdata = 0; mem_wdata = 0; wb_wdata = 0;
        ex_data_ok = 0; mem_data_ok = 0; wb_retire = 0; flush = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        id_fire = 1; id_rf_we = 1; id_waddr = r;
        next();
        id_fire = 0; id_rf_we = 0; id_waddr = 0;
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1; wb_we = 1; wb_waddr = r; wb_retire = 1; wb_wdata = 32'h5A5A_0000 | 32'(r);
        next();
        wb_valid = 0; wb_we = 0; wb_waddr = 0; wb_retire = 0; wb_wdata = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        next(); next();
        reset = 0;
        chk_en = 1;
        #2;
        check("rst_pause", pause, 0);
        check("rst_occur1", addr1_occur, 0);
        check("rst_occur2", addr2_occur, 0);
        check("rst_sb_err", sb_err, 0);

        // 1: EX -> ID ALU bypass
        next();
        issue(5);
        ex_valid = 1; ex_we = 1; ex_waddr = 5; ex_wdata = 32'h1234; ex_data_ok = 1;
        id_valid = 1; id_raddr1 = 5;
        #2;
        check("t1_occur1", addr1_occur, 1);
        check("t1_fwd1", addr1_forward, 32'h1234);
        check("t1_pause", pause, 0);
        next(); idle();
        retire(5);
        id_valid = 1; id_raddr1 = 5;
        #2 check("t1_drained", pause, 0);
        next(); idle();

        // 2: load-use stall, releases when MEM data becomes ready
        issue(7);
        ex_valid = 1; ex_we = 1; ex_waddr = 7; ex_data_ok = 0;
        id_valid = 1; id_raddr2 = 7;
        #2 check("t2_stall_ex", pause, 1);
        next();
        ex_valid = 0; ex_we = 0; ex_waddr = 0;
        mem_valid = 1; mem_we = 1; mem_waddr = 7; mem_data_ok = 0;
        #2 check("t2_stall_mem1", pause, 1);
        next();
        #2 check("t2_stall_mem2", pause, 1);
        next();
        mem_data_ok = 1; mem_wdata = 32'hDEADBEEF;
        #2;
        check("t2_release", pause, 0);
        check("t2_occur2", addr2_occur, 1);
        check("t2_fwd2", addr2_forward, 32'hDEADBEEF);
        next(); idle();
        retire(7);

        // 3: youngest writer wins
        issue(3); issue(3); issue(3);
        ex_valid = 1;  ex_we = 1;  ex_waddr = 3;  ex_wdata = 32'hA;  ex_data_ok = 1;
        mem_valid = 1; mem_we = 1; mem_waddr = 3; mem_wdata = 32'hB; mem_data_ok = 1;
        wb_valid = 1;  wb_we = 1;  wb_waddr = 3;  wb_wdata = 32'hC;
        id_valid = 1; id_raddr1 = 3; id_raddr2 = 3;
        #2;
        check("t3_fwd1_ex", addr1_forward, 32'hA);
        check("t3_fwd2_ex", addr2_forward, 32'hA);
        check("t3_pause0", pause, 0);
        next();
        ex_data_ok = 0;
        #2;
        check("t3_no_fallthru", pause, 1);
        check("t3_occur1_off", addr1_occur, 0);
        next();
        ex_valid = 0;
        #2 check("t3_fwd1_mem", addr1_forward, 32'hB);
        next();
        mem_valid = 0;
        #2 check("t3_fwd1_wb", addr1_forward, 32'hC);
        next(); idle();
        retire(3); retire(3); retire(3);

        // 5A: r0 is never a hazard
        id_valid = 1; id_raddr1 = 0; id_raddr2 = 0;
        ex_valid = 1; ex_we = 1; ex_waddr = 0; ex_data_ok = 0;
        id_fire = 1; id_rf_we = 1; id_waddr = 0;
        #2;
        check("t5a_occur1", addr1_occur, 0);
        check("t5a_pause", pause, 0);
        next(); idle();

        // 5B: flush clears the scoreboard, drops the issue, tolerates WB retire
        issue(9); issue(9); issue(11);
        flush = 1;
        id_valid = 1; id_raddr1 = 9;
        id_fire = 1; id_rf_we = 1; id_waddr = 10;
        wb_valid = 1; wb_we = 1; wb_waddr = 11; wb_retire = 1;
        #2 check("t5b_flush_pause", pause, 0);
        next(); idle();
        id_valid = 1; id_raddr1 = 9; id_raddr2 = 10;
        #2;
        check("t5b_r9_free", pause, 0);
        check("t5b_no_err", sb_err, 0);
        next();
        id_raddr1 = 11; id_raddr2 = 0;
        #2 check("t5b_r11_free", pause, 0);
        next(); idle();

        // 4: concurrent issue/retire, then overflow
        issue(4);
        id_fire = 1; id_rf_we = 1; id_waddr = 4;
        wb_valid = 1; wb_we = 1; wb_waddr = 4; wb_retire = 1;
        next(); idle();
        id_valid = 1; id_raddr1 = 4;
        #2 check("t4_cnt_still1", pause, 1);
        next(); idle();
        retire(4);
        id_valid = 1; id_raddr1 = 4;
        #2 check("t4_cnt_zero", pause, 0);
        next(); idle();
        issue(4); issue(4); issue(4);
        #2 check("t4_no_err_at3", sb_err, 0);
        issue(4);
        #2 check("t4_overflow", sb_err, 1);
        retire(4); retire(4); retire(4);
        id_valid = 1; id_raddr1 = 4;
        #2 check("t4_saturated_drain", pause, 0);
        next(); idle();

        // 6: synchronous reset mid-stall
        issue(12);
        id_valid = 1; id_raddr1 = 12;
        #2 check("t6_stalled", pause, 1);
        next();
        reset = 1;
        next();
        reset = 0;
        #2;
        check("t6_pause_after_rst", pause, 0);
        check("t6_err_cleared", sb_err, 0);
        next(); idle();
        retire(6);
        #2 check("t6_underflow", sb_err, 1);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
